vend_controller: RTL and testbench

Sequencing controller for a multi-slot vending machine. Accumulates coin credit, arbitrates round-robin between product-select buttons, and drives a shared dispenser motor and a shared change-return unit through req/done handshakes. Sits between the coin acceptor and button panel on one side and the dispenser and change unit on the other.

---
 rtl/vend_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/vend_controller.sv | 176 +++++++++++++++++
 tb/tb_vend_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine controller.
// State encodings are one-hot so that any corrupted pattern can be detected.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    DISPENSE = 3'b010,
    CHANGE   = 3'b100
  } state_t;

  localparam int QUARTER_VAL = 1;
  localparam int DOLLAR_VAL  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps around.
// The pointer register itself lives in the parent so that it only advances on a real grant.
module rr_arbiter #(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0]         i_req,
  input  logic [$clog2(NUM_SLOTS)-1:0] i_ptr,
  output logic                         o_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] o_idx
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  // Scan from farthest to nearest so the slot closest to the pointer overwrites the others.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (i_req[(int'(i_ptr) + i) % NUM_SLOTS]) begin
        o_valid = 1'b1;
        o_idx   = SLOT_W'((int'(i_ptr) + i) % NUM_SLOTS);
      end
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending-machine sequencer: coin credit, round-robin product select, and
// req/done handshakes to the shared dispenser and change-return units.
//
// state    | meaning
// IDLE     | accept coins, arbitrate selects, honour cancel
// DISPENSE | Disp_Req held for Disp_Slot until Disp_Done
// CHANGE   | Change_Req held, one quarter returned per Change_Done
module vend_controller #(
  parameter int NUM_SLOTS  = 4,
  parameter int PRICE_Q    = 3,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Quarter_In,
  input  logic                         Dollar_In,
  input  logic                         Cancel,
  input  logic [NUM_SLOTS-1:0]         Select,
  input  logic [NUM_SLOTS-1:0]         Slot_Empty,
  input  logic                         Disp_Done,
  input  logic                         Change_Done,
  output logic                         Disp_Req,
  output logic [$clog2(NUM_SLOTS)-1:0] Disp_Slot,
  output logic                         Change_Req,
  output logic                         Coin_Reject,
  output logic [CREDIT_W-1:0]          Credit,
  output logic                         Busy
);

  import vend_pkg::*;

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE_Q);
  localparam logic [CREDIT_W-1:0] MAX_C     = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(QUARTER_VAL);
  localparam logic [CREDIT_W-1:0] DOLLAR_C  = CREDIT_W'(DOLLAR_VAL);

  state_t                r_state;
  logic [CREDIT_W-1:0]   r_credit;
  logic [SLOT_W-1:0]     r_ptr;
  logic                  r_disp_req;
  logic [SLOT_W-1:0]     r_disp_slot;
  logic                  r_change_req;
  logic                  r_coin_reject;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [CREDIT_W-1:0]   w_credit_nxt;
  logic [CREDIT_W-1:0]   w_coin_credit;
  logic [SLOT_W-1:0]     w_ptr_nxt;
  logic                  w_disp_req_nxt;
  logic [SLOT_W-1:0]     w_disp_slot_nxt;
  logic                  w_change_req_nxt;
  logic                  w_reject_nxt;
  logic [CREDIT_W:0]     w_sum_d;
  logic [CREDIT_W:0]     w_sum_q;
  logic [NUM_SLOTS-1:0]  w_req;
  logic                  w_gnt_valid;
  logic [SLOT_W-1:0]     w_gnt_idx;

  assign w_req   = Select & ~Slot_Empty;
  assign w_sum_d = {1'b0, r_credit} + {1'b0, DOLLAR_C};
  assign w_sum_q = {1'b0, r_credit} + {1'b0, QUARTER_C};

  rr_arbiter #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_arb (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .o_valid(w_gnt_valid),
    .o_idx  (w_gnt_idx)
  );

  always_comb begin
    w_state_nxt      = IDLE;
    w_credit_nxt     = r_credit;
    w_coin_credit    = r_credit;
    w_ptr_nxt        = r_ptr;
    w_disp_req_nxt   = 1'b0;
    w_disp_slot_nxt  = r_disp_slot;
    w_change_req_nxt = 1'b0;
    w_reject_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        // A simultaneous quarter is always bounced; the dollar gets first claim on headroom.
        if (Dollar_In) begin
          if (w_sum_d > {1'b0, MAX_C}) w_reject_nxt  = 1'b1;
          else                          w_coin_credit = w_sum_d[CREDIT_W-1:0];
          if (Quarter_In) w_reject_nxt = 1'b1;
        end else if (Quarter_In) begin
          if (w_sum_q > {1'b0, MAX_C}) w_reject_nxt  = 1'b1;
          else                          w_coin_credit = w_sum_q[CREDIT_W-1:0];
        end

        w_credit_nxt = w_coin_credit;
        if (w_gnt_valid && (r_credit >= PRICE_C)) begin
          w_state_nxt     = DISPENSE;
          w_disp_req_nxt  = 1'b1;
          w_disp_slot_nxt = w_gnt_idx;
          w_credit_nxt    = w_coin_credit - PRICE_C;
          w_ptr_nxt       = (w_gnt_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : w_gnt_idx + SLOT_W'(1);
        end else if (Cancel && (r_credit != '0)) begin
          w_state_nxt      = CHANGE;
          w_change_req_nxt = 1'b1;
        end
      end

      DISPENSE: begin
        w_reject_nxt   = Quarter_In | Dollar_In;
        w_state_nxt    = DISPENSE;
        w_disp_req_nxt = 1'b1;
        if (Disp_Done) begin
          w_disp_req_nxt = 1'b0;
          if (r_credit != '0) begin
            w_state_nxt      = CHANGE;
            w_change_req_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      CHANGE: begin
        w_reject_nxt     = Quarter_In | Dollar_In;
        w_state_nxt      = CHANGE;
        w_change_req_nxt = 1'b1;
        if (r_credit == '0) begin
          w_state_nxt      = IDLE;
          w_change_req_nxt = 1'b0;
        end else if (Change_Done) begin
          w_credit_nxt = r_credit - CREDIT_W'(1);
          if (r_credit == CREDIT_W'(1)) begin
            w_state_nxt      = IDLE;
            w_change_req_nxt = 1'b0;
          end
        end
      end

      default: begin
        w_reject_nxt = Quarter_In | Dollar_In;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_ptr         <= '0;
      r_disp_req    <= 1'b0;
      r_disp_slot   <= '0;
      r_change_req  <= 1'b0;
      r_coin_reject <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_ptr         <= w_ptr_nxt;
      r_disp_req    <= w_disp_req_nxt;
      r_disp_slot   <= w_disp_slot_nxt;
      r_change_req  <= w_change_req_nxt;
      r_coin_reject <= w_reject_nxt;
      r_busy        <= (w_state_nxt == DISPENSE) || (w_state_nxt == CHANGE);
    end
  end

  assign Disp_Req    = r_disp_req;
  assign Disp_Slot   = r_disp_slot;
  assign Change_Req  = r_change_req;
  assign Coin_Reject = r_coin_reject;
  assign Credit      = r_credit;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: each driven cycle queues the expected
// registered outputs, and a monitor compares them one cycle later.
module tb_vend_controller;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Quarter_In = 1'b0;
  logic       Dollar_In = 1'b0;
  logic       Cancel = 1'b0;
  logic [3:0] Select = '0;
  logic [3:0] Slot_Empty = '0;
  logic       Disp_Done = 1'b0;
  logic       Change_Done = 1'b0;
  logic       Disp_Req;
  logic [1:0] Disp_Slot;
  logic       Change_Req;
  logic       Coin_Reject;
  logic [3:0] Credit;
  logic       Busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;
  sb_t sb[$];

  vend_controller #(
    .NUM_SLOTS(4), .PRICE_Q(3), .CREDIT_W(4), .MAX_CREDIT(8)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Quarter_In(Quarter_In), .Dollar_In(Dollar_In),
    .Cancel(Cancel), .Select(Select), .Slot_Empty(Slot_Empty), .Disp_Done(Disp_Done),
    .Change_Done(Change_Done), .Disp_Req(Disp_Req), .Disp_Slot(Disp_Slot),
    .Change_Req(Change_Req), .Coin_Reject(Coin_Reject), .Credit(Credit), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Snapshot layout: busy, disp_req, disp_slot[1:0], change_req, coin_reject, credit[3:0]
  function automatic logic [9:0] ex(input logic b, input logic dr, input logic [1:0] sl,
                                    input logic cr, input logic rj, input logic [3:0] cd);
    return {b, dr, sl, cr, rj, cd};
  endfunction

  function automatic logic [9:0] snap();
    return {Busy, Disp_Req, Disp_Slot, Change_Req, Coin_Reject, Credit};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got b=%0b dr=%0b sl=%0d cr=%0b rj=%0b cred=%0d, want b=%0b dr=%0b sl=%0d cr=%0b rj=%0b cred=%0d",
               tag, obs[9], obs[8], obs[7:6], obs[5], obs[4], obs[3:0],
               exp[9], exp[8], exp[7:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic drv(input string tag, input logic q, input logic d, input logic c,
                     input logic [3:0] sel, input logic [3:0] emp,
                     input logic dd, input logic chd, input logic [9:0] exp);
    @(negedge Clock);
    Quarter_In  = q;
    Dollar_In   = d;
    Cancel      = c;
    Select      = sel;
    Slot_Empty  = emp;
    Disp_Done   = dd;
    Change_Done = chd;
    sb.push_back('{tag, exp});
  endtask

  // Disp_Slot is only meaningful while Disp_Req is expected high.
  initial begin
    sb_t        e;
    logic [9:0] o;
    forever begin
      @(posedge Clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        o = snap();
        if (!e.exp[8]) begin
          o[7:6]     = 2'b00;
          e.exp[7:6] = 2'b00;
        end
        chk(e.tag, o, e.exp);
      end
    end
  end

  initial begin
    #3;
    chk("rst_init", snap(), 10'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // three quarters then exact-price purchase from slot 0
    drv("q1",        1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,1));
    drv("q2",        1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,2));
    drv("q3",        1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,3));
    drv("sel0",      0,0,0, 4'b0001,4'b0000, 0,0, ex(1,1,0,0,0,0));
    drv("disp_hold", 0,0,0, 4'b0000,4'b0000, 0,0, ex(1,1,0,0,0,0));
    drv("done0",     0,0,0, 4'b0000,4'b0000, 1,0, ex(0,0,0,0,0,0));
    drv("idle0",     0,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,0));

    // dollar, slot 2, one quarter change
    drv("dollar",    0,1,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,4));
    drv("sel2",      0,0,0, 4'b0100,4'b0000, 0,0, ex(1,1,2,0,0,1));
    drv("done2",     0,0,0, 4'b0000,4'b0000, 1,0, ex(1,0,0,1,0,1));
    drv("chg_hold",  0,0,0, 4'b0000,4'b0000, 0,0, ex(1,0,0,1,0,1));
    drv("chg_done",  0,0,0, 4'b0000,4'b0000, 0,1, ex(0,0,0,0,0,0));

    // reach DISPENSE with credit 5 (pointer at 3), then async reset
    drv("d_a",       0,1,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,4));
    drv("d_b_max",   0,1,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,8));
    drv("sel3",      0,0,0, 4'b1000,4'b0000, 0,0, ex(1,1,3,0,0,5));
    @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    chk("rst_mid", snap(), 10'd0);
    @(negedge Clock);
    Reset = 1'b1;
    drv("post_rst",  0,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,0));

    // credit 6, all selected, slot 1 empty, pointer back at 0
    drv("d6",        0,1,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,4));
    drv("q6a",       1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,5));
    drv("q6b",       1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,6));
    drv("rr_g0",     0,0,0, 4'b1111,4'b0010, 0,0, ex(1,1,0,0,0,3));
    drv("rr_dd0",    0,0,0, 4'b1111,4'b0010, 1,0, ex(1,0,0,1,0,3));
    drv("rr_cd3",    0,0,0, 4'b1111,4'b0010, 0,1, ex(1,0,0,1,0,2));
    drv("rr_cd2",    0,0,0, 4'b1111,4'b0010, 0,1, ex(1,0,0,1,0,1));
    drv("rr_cd1",    0,0,0, 4'b1111,4'b0010, 0,1, ex(0,0,0,0,0,0));
    drv("rr_q1",     1,0,0, 4'b1111,4'b0010, 0,0, ex(0,0,0,0,0,1));
    drv("rr_q2",     1,0,0, 4'b1111,4'b0010, 0,0, ex(0,0,0,0,0,2));
    drv("rr_q3_nog", 1,0,0, 4'b1111,4'b0010, 0,0, ex(0,0,0,0,0,3));
    drv("rr_g2",     0,0,0, 4'b1111,4'b0010, 0,0, ex(1,1,2,0,0,0));
    drv("rr_dd2",    0,0,0, 4'b0000,4'b0000, 1,0, ex(0,0,0,0,0,0));

    // overflow reject, reject during DISPENSE (pointer at 3 wraps to slot 0)
    drv("ov_d",      0,1,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,4));
    drv("ov_q",      1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,5));
    drv("ov_rej",    0,1,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,1,5));
    drv("ov_clr",    0,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,5));
    drv("wrap_g0",   0,0,0, 4'b0001,4'b0000, 0,0, ex(1,1,0,0,0,2));
    drv("disp_rej",  1,0,0, 4'b0000,4'b0000, 0,0, ex(1,1,0,0,1,2));
    drv("dd_chg",    0,0,0, 4'b0000,4'b0000, 1,0, ex(1,0,0,1,0,2));
    drv("cd_a",      0,0,0, 4'b0000,4'b0000, 0,1, ex(1,0,0,1,0,1));
    drv("cd_b",      0,0,0, 4'b0000,4'b0000, 0,1, ex(0,0,0,0,0,0));

    // dollar+quarter together, cancel, reject in CHANGE, drain 5
    drv("dq_pre",    1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,1));
    drv("dq_both",   1,1,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,1,5));
    drv("cxl5",      0,0,1, 4'b0000,4'b0000, 0,0, ex(1,0,0,1,0,5));
    drv("chg_rej",   0,1,0, 4'b0000,4'b0000, 0,0, ex(1,0,0,1,1,5));
    for (int k = 4; k >= 1; k--)
      drv("drain",   0,0,0, 4'b0000,4'b0000, 0,1, ex(1,0,0,1,0,4'(k)));
    drv("drain_end", 0,0,0, 4'b0000,4'b0000, 0,1, ex(0,0,0,0,0,0));

    // low credit select, cancel with credit 2, stray pulses, cancel at zero
    drv("lc_q1",     1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,1));
    drv("lc_q2",     1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,2));
    drv("lc_sel",    0,0,0, 4'b0001,4'b0000, 0,0, ex(0,0,0,0,0,2));
    drv("lc_stray",  0,0,0, 4'b0000,4'b0000, 1,1, ex(0,0,0,0,0,2));
    drv("lc_cxl",    0,0,1, 4'b0000,4'b0000, 0,0, ex(1,0,0,1,0,2));
    drv("lc_cd1",    0,0,0, 4'b0000,4'b0000, 0,1, ex(1,0,0,1,0,1));
    drv("lc_hold",   0,0,0, 4'b0000,4'b0000, 0,0, ex(1,0,0,1,0,1));
    drv("lc_cd0",    0,0,0, 4'b0000,4'b0000, 0,1, ex(0,0,0,0,0,0));
    drv("cxl_zero",  0,0,1, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,0));

    // select beats cancel in the same cycle; empty-only select is ignored
    drv("sc_q1",     1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,1));
    drv("sc_q2",     1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,2));
    drv("sc_q3",     1,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,3));
    drv("empty_sel", 0,0,0, 4'b0010,4'b0010, 0,0, ex(0,0,0,0,0,3));
    drv("sel_cxl",   0,0,1, 4'b0010,4'b0000, 0,0, ex(1,1,1,0,0,0));
    drv("sc_dd",     0,0,0, 4'b0000,4'b0000, 1,0, ex(0,0,0,0,0,0));
    drv("final",     0,0,0, 4'b0000,4'b0000, 0,0, ex(0,0,0,0,0,0));

    repeat (2) @(posedge Clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
